// File: rtl/cam_rgb565_capture_pkg.sv
// Shared types and constants for the camera RGB565 capture path.
// Field positions are for the 16-bit word {first byte, second byte}.
package cam_pkg;

  localparam int unsigned DEFAULT_IMG_WIDTH  = 640;
  localparam int unsigned DEFAULT_IMG_HEIGHT = 480;

  localparam int unsigned RGB565_R_MSB = 15;
  localparam int unsigned RGB565_R_LSB = 11;
  localparam int unsigned RGB565_G_MSB = 10;
  localparam int unsigned RGB565_G_LSB = 5;
  localparam int unsigned RGB565_B_MSB = 4;
  localparam int unsigned RGB565_B_LSB = 0;

  typedef enum logic [1:0] {
    S_WAIT_VSYNC = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_HI         = 2'd2,
    S_LO         = 2'd3
  } cam_state_t;

endpackage

// File: rtl/cam_rgb565_capture_rgb565_to_rgb888.sv
// Combinational RGB565 -> RGB888 expansion by MSB replication.
module rgb565_to_rgb888
  import cam_pkg::*;
(
  input  logic [15:0] pix_i,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o
);

  logic [4:0] w_r5;
  logic [5:0] w_g6;
  logic [4:0] w_b5;

  assign w_r5 = pix_i[RGB565_R_MSB:RGB565_R_LSB];
  assign w_g6 = pix_i[RGB565_G_MSB:RGB565_G_LSB];
  assign w_b5 = pix_i[RGB565_B_MSB:RGB565_B_LSB];

  assign red_o   = {w_r5, w_r5[4:2]};
  assign green_o = {w_g6, w_g6[5:4]};
  assign blue_o  = {w_b5, w_b5[4:2]};

endmodule

// File: rtl/cam_rgb565_capture.sv
// Camera RGB565 byte-stream capture with pixel/line tracking and frame checks.
// Optional CAM_TEST_PATTERN_EN adds pattern_sel_i (8 vertical colour bars).
module cam_rgb565_capture
  import cam_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef CAM_TEST_PATTERN_EN
  input  logic                          pattern_sel_i,
`endif
  input  logic [7:0]                    cam_data_i,
  input  logic                          cam_byte_valid_i,
  input  logic                          cam_href_i,
  input  logic                          cam_vsync_i,
  output logic [7:0]                    red_o,
  output logic [7:0]                    green_o,
  output logic [7:0]                    blue_o,
  output logic                          done_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  x_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] y_o,
  output logic                          frame_done_o,
  output logic                          frame_err_o
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  // Counters are one count wider than x/y so they can hold the "past the end" value.
  localparam int unsigned CW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [CW-1:0] COL_LIMIT = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LIMIT = RW'(IMG_HEIGHT);

  cam_state_t    r_state;
  logic [7:0]    r_hi_byte;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_bad;
  logic          r_line_seen;
  logic          r_href_d;
  logic          r_vsync_d;

  logic          w_in_frame;
  logic          w_byte;
  logic          w_href_fall;
  logic          w_vsync_rise;
  logic          w_in_range;
  logic [7:0]    w_cam_r;
  logic [7:0]    w_cam_g;
  logic [7:0]    w_cam_b;
  logic [7:0]    w_pix_r;
  logic [7:0]    w_pix_g;
  logic [7:0]    w_pix_b;

  assign w_in_frame   = (r_state == S_HI) || (r_state == S_LO);
  assign w_byte       = w_in_frame && cam_href_i && cam_byte_valid_i;
  assign w_href_fall  = r_href_d && !cam_href_i;
  assign w_vsync_rise = cam_vsync_i && !r_vsync_d;
  assign w_in_range   = (r_col < COL_LIMIT) && (r_row < ROW_LIMIT);

  rgb565_to_rgb888 u_expand (
    .pix_i   ({r_hi_byte, cam_data_i}),
    .red_o   (w_cam_r),
    .green_o (w_cam_g),
    .blue_o  (w_cam_b)
  );

`ifdef CAM_TEST_PATTERN_EN
  logic [2:0] w_bar;
  assign w_bar   = 3'((32'(r_col) * 32'd8) / 32'(IMG_WIDTH));
  assign w_pix_r = pattern_sel_i ? {8{w_bar[2]}} : w_cam_r;
  assign w_pix_g = pattern_sel_i ? {8{w_bar[1]}} : w_cam_g;
  assign w_pix_b = pattern_sel_i ? {8{w_bar[0]}} : w_cam_b;
`else
  assign w_pix_r = w_cam_r;
  assign w_pix_g = w_cam_g;
  assign w_pix_b = w_cam_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT_VSYNC;
      r_hi_byte    <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_bad        <= 1'b0;
      r_line_seen  <= 1'b0;
      r_href_d     <= 1'b0;
      r_vsync_d    <= 1'b0;
      red_o        <= '0;
      green_o      <= '0;
      blue_o       <= '0;
      done_o       <= 1'b0;
      x_o          <= '0;
      y_o          <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      r_href_d     <= cam_href_i;
      r_vsync_d    <= cam_vsync_i;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;

      case (r_state)
        S_WAIT_VSYNC: begin
          if (cam_vsync_i) r_state <= S_WAIT_FRAME;
        end

        S_WAIT_FRAME: begin
          if (!cam_vsync_i) r_state <= S_HI;
        end

        S_HI, S_LO: begin
          if (w_vsync_rise) begin
            if ((r_row == ROW_LIMIT) && !r_bad) frame_done_o <= 1'b1;
            else                                frame_err_o  <= 1'b1;
            r_state     <= S_WAIT_FRAME;
            r_col       <= '0;
            r_row       <= '0;
            r_bad       <= 1'b0;
            r_line_seen <= 1'b0;
          end else if (w_href_fall) begin
            r_state <= S_HI;
            if (r_state == S_LO) r_bad <= 1'b1;
            if (r_line_seen) begin
              r_col <= '0;
              // Line count saturates at the frame height; any further line is an error.
              if (r_row == ROW_LIMIT) r_bad <= 1'b1;
              else                    r_row <= r_row + RW'(1);
            end
            r_line_seen <= 1'b0;
          end else if (w_byte) begin
            r_line_seen <= 1'b1;
            if (r_state == S_HI) begin
              r_hi_byte <= cam_data_i;
              r_state   <= S_LO;
            end else begin
              r_state <= S_HI;
              if (w_in_range) begin
                done_o  <= 1'b1;
                red_o   <= w_pix_r;
                green_o <= w_pix_g;
                blue_o  <= w_pix_b;
                x_o     <= r_col[XW-1:0];
                y_o     <= r_row[YW-1:0];
                r_col   <= r_col + CW'(1);
              end else begin
                r_bad <= 1'b1;
              end
            end
          end
        end

        default: r_state <= S_WAIT_VSYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Directed, table-driven bench for cam_rgb565_capture on a 4x2 frame.
module tb_cam_rgb565_capture;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] cam_data;
  logic       cam_valid;
  logic       cam_href;
  logic       cam_vsync;

  logic [7:0] red, green, blue;
  logic       done;
  logic [1:0] x;
  logic       y;
  logic       frame_done, frame_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n_done = 0;

`ifdef CAM_TEST_PATTERN_EN
  logic       pat_off = 1'b0;
  logic       pat_on  = 1'b1;
  logic [7:0] p_red, p_green, p_blue;
  logic       p_done, p_fdone, p_ferr;
  logic [2:0] p_x;
  logic       p_y;

  cam_rgb565_capture #(.IMG_WIDTH(8), .IMG_HEIGHT(2)) u_pat (
    .clk(clk), .rst(rst), .pattern_sel_i(pat_on),
    .cam_data_i(cam_data), .cam_byte_valid_i(cam_valid),
    .cam_href_i(cam_href), .cam_vsync_i(cam_vsync),
    .red_o(p_red), .green_o(p_green), .blue_o(p_blue), .done_o(p_done),
    .x_o(p_x), .y_o(p_y), .frame_done_o(p_fdone), .frame_err_o(p_ferr)
  );
`endif

  cam_rgb565_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
`ifdef CAM_TEST_PATTERN_EN
    .pattern_sel_i(pat_off),
`endif
    .cam_data_i(cam_data), .cam_byte_valid_i(cam_valid),
    .cam_href_i(cam_href), .cam_vsync_i(cam_vsync),
    .red_o(red), .green_o(green), .blue_o(blue), .done_o(done),
    .x_o(x), .y_o(y), .frame_done_o(frame_done), .frame_err_o(frame_err)
  );

  always @(negedge clk) if (done) n_done++;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int unsigned gap;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [1:0]  px;
    logic        py;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    cam_data  = b;
    cam_valid = 1'b1;
    tick();
    cam_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  done,       0);
    chk({tag, "_red"},   red,        0);
    chk({tag, "_green"}, green,      0);
    chk({tag, "_blue"},  blue,       0);
    chk({tag, "_x"},     x,          0);
    chk({tag, "_y"},     y,          0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_ferr"},  frame_err,  0);
  endtask

  task automatic send_line4();
    for (int p = 0; p < 4; p++) begin
      put_byte(8'h12);
      put_byte(8'h34);
    end
    cam_href = 1'b0; tick();
    cam_href = 1'b1; tick();
  endtask

  int unsigned base;

  initial begin
    //               hi     lo   gap  R      G      B      x  y
    vecs[0] = '{8'hF8, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0};
    vecs[1] = '{8'h07, 8'hE0, 2, 8'h00, 8'hFF, 8'h00, 1, 0};
    vecs[2] = '{8'h08, 8'h41, 0, 8'h08, 8'h08, 8'h08, 2, 0};
    vecs[3] = '{8'h00, 8'h1F, 1, 8'h00, 8'h00, 8'hFF, 3, 0};
    vecs[4] = '{8'h07, 8'hE0, 3, 8'h00, 8'hFF, 8'h00, 0, 1};
    vecs[5] = '{8'h08, 8'h41, 0, 8'h08, 8'h08, 8'h08, 1, 1};
    vecs[6] = '{8'hA5, 8'h5A, 1, 8'hA5, 8'hAA, 8'hD6, 2, 1};
    vecs[7] = '{8'h12, 8'h34, 0, 8'h10, 8'h45, 8'hA5, 3, 1};

    rst = 1'b1; cam_data = '0; cam_valid = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0;
    idle(2);
    chk_all_zero("reset");
    rst = 1'b0;

    // Clean 4x2 frame with valid gaps
    cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; tick();
    cam_href = 1'b1; tick();
    base = n_done;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        cam_href = 1'b0; tick();
        cam_href = 1'b1; tick();
      end
      put_byte(vecs[i].hi);
      idle(vecs[i].gap);
      put_byte(vecs[i].lo);
      chk($sformatf("pix%0d_done", i),  done,  1);
      chk($sformatf("pix%0d_red", i),   red,   vecs[i].r);
      chk($sformatf("pix%0d_green", i), green, vecs[i].g);
      chk($sformatf("pix%0d_blue", i),  blue,  vecs[i].b);
      chk($sformatf("pix%0d_x", i),     x,     vecs[i].px);
      chk($sformatf("pix%0d_y", i),     y,     vecs[i].py);
      tick();
      chk($sformatf("pix%0d_done_pulse", i), done, 0);
    end
    cam_href = 1'b0; tick();
    chk("f1_fdone_early", frame_done, 0);
    cam_vsync = 1'b1; tick();
    chk("f1_fdone", frame_done, 1);
    chk("f1_ferr", frame_err, 0);
    tick();
    chk("f1_fdone_pulse", frame_done, 0);
    chk("f1_done_count", n_done - base, 8);

    // Partial pixel on line 0 marks the frame bad
    cam_vsync = 1'b0; tick();
    cam_href = 1'b1; tick();
    base = n_done;
    put_byte(8'hF8); put_byte(8'h00);
    chk("f2_p0_done", done, 1);
    chk("f2_p0_red", red, 8'hFF);
    tick();
    put_byte(8'h07);
    cam_href = 1'b0; tick();
    cam_href = 1'b1; tick();
    put_byte(8'h08); put_byte(8'h41);
    chk("f2_p1_done", done, 1);
    chk("f2_p1_x", x, 0);
    chk("f2_p1_y", y, 1);
    chk("f2_p1_blue", blue, 8'h08);
    cam_href = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    chk("f2_ferr", frame_err, 1);
    chk("f2_fdone", frame_done, 0);
    tick();
    chk("f2_ferr_pulse", frame_err, 0);
    chk("f2_done_count", n_done - base, 2);

    // Column overflow: fifth pixel on a 4-wide line is dropped
    cam_vsync = 1'b0; tick();
    cam_href = 1'b1; tick();
    for (int p = 0; p < 5; p++) begin
      put_byte(8'h00); put_byte(8'h1F);
      chk($sformatf("f3_p%0d_done", p), done, (p < 4) ? 1 : 0);
      if (p < 4) chk($sformatf("f3_p%0d_x", p), x, p);
    end
    cam_href = 1'b0; tick();
    cam_href = 1'b1; tick();
    put_byte(8'h00); put_byte(8'h1F);
    chk("f3_l1_done", done, 1);
    chk("f3_l1_x", x, 0);
    cam_href = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    chk("f3_ferr", frame_err, 1);
    chk("f3_fdone", frame_done, 0);
    tick();

    // Reset mid-line, then ignore bytes until a full vsync high->low
    cam_vsync = 1'b0; tick();
    cam_href = 1'b1; tick();
    put_byte(8'hF8); put_byte(8'h00);
    put_byte(8'h08); put_byte(8'h41);
    chk("f4_pre_x", x, 1);
    chk("f4_pre_red", red, 8'h08);
    put_byte(8'h07);
    rst = 1'b1; cam_data = 8'hE0; cam_valid = 1'b1;
    tick();
    rst = 1'b0; cam_valid = 1'b0;
    chk_all_zero("midrst");
    base = n_done;
    put_byte(8'h07); put_byte(8'hE0);
    chk("f4_ignored_done", done, 0);
    put_byte(8'hF8); put_byte(8'h00);
    chk("f4_ignored_red", red, 0);
    cam_href = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    chk("f4_vs_fdone", frame_done, 0);
    chk("f4_vs_ferr", frame_err, 0);
    cam_vsync = 1'b0; tick();
    cam_href = 1'b1; tick();
    send_line4();
    send_line4();
    cam_href = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    chk("f5_fdone", frame_done, 1);
    chk("f5_ferr", frame_err, 0);
    chk("f5_done_count", n_done - base, 8);
    tick();

`ifdef CAM_TEST_PATTERN_EN
    cam_vsync = 1'b0; tick();
    cam_href = 1'b1; tick();
    for (int p = 0; p < 6; p++) begin
      put_byte(8'h12); put_byte(8'h34);
    end
    chk("pat_done", p_done, 1);
    chk("pat_x", p_x, 5);
    chk("pat_red", p_red, 8'hFF);
    chk("pat_green", p_green, 8'h00);
    chk("pat_blue", p_blue, 8'hFF);
    cam_href = 1'b0; tick();
    cam_vsync = 1'b1; tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_rgb565_capture.md
# cam_rgb565_capture

Camera-side pixel source for the grayscale/Sobel pipeline. Receives the camera's RGB565 byte stream (two bytes per pixel, framed by VSYNC/HREF), reassembles each pixel, and expands it to 8-bit red/green/blue. It then presents the pixel with a one-cycle `done_o` strobe, the exact handshake `rgb_to_grayscale` consumes on `red_i/green_i/blue_i/cam_done_i`. It also tracks pixel/line position and flags complete or malformed frames.

## Interface
- `IMG_WIDTH`, 640, pixels per line
- `IMG_HEIGHT`, 480, lines per frame
- `clk`  in  1  system clock; all camera inputs pre-synchronised to it
- `rst`  in  1  synchronous, active-high reset
- `cam_data_i`  in  8  camera byte
- `cam_byte_valid_i`  in  1  qualifies `cam_data_i` this cycle
- `cam_href_i`  in  1  line-active
- `cam_vsync_i`  in  1  frame sync; high = blanking between frames
- `red_o`, `green_o`, `blue_o`  out  8 each  expanded pixel
- `done_o`  out  1  one-cycle pixel-valid strobe
- `x_o`  out  $clog2(IMG_WIDTH)  column of the pixel on `done_o`
- `y_o`  out  $clog2(IMG_HEIGHT)  line of the pixel on `done_o`
- `frame_done_o`  out  1  one-cycle pulse: full frame received
- `frame_err_o`  out  1  one-cycle pulse: frame aborted or malformed

## Operation
- FSM states: `S_WAIT_VSYNC` (await vsync high), `S_WAIT_FRAME` (await vsync low), `S_HI` (expect first byte), `S_LO` (expect second byte).
- Reset enters `S_WAIT_VSYNC`. All outputs, counters and byte latch are 0.
- Byte accepted only when `cam_href_i && cam_byte_valid_i` in `S_HI`/`S_LO`.
- First byte is `{R[4:0], G[5:3]}`, latched, and moves to `S_LO`. Second byte is `{G[2:0], B[4:0]}`, completes the pixel, and returns to `S_HI`.
- Expansion by MSB replication: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
- Column counter increments per completed pixel.
  - Pixels at column ≥ `IMG_WIDTH` are dropped: no `done_o`, counter saturates, and the frame is marked bad.
- HREF falling edge:
  - A partial pixel (in `S_LO`) is discarded; the frame is marked bad; the FSM returns to `S_HI`.
  - If ≥1 byte was accepted on that line, the line counter increments and the column counter clears.
  - Lines beyond `IMG_HEIGHT` mark the frame bad and produce no `done_o`.
- VSYNC rising edge while in `S_HI`/`S_LO` ends the frame and moves to `S_WAIT_FRAME`; counters clear.
  - Line count == `IMG_HEIGHT` and not bad: pulse `frame_done_o`.
  - Otherwise: pulse `frame_err_o`.
- The first frame after reset is captured only after a full vsync high→low sequence. Partial frames in progress at reset are ignored silently.

## Timing
- `red_o/green_o/blue_o/x_o/y_o/done_o` are registered. `done_o` is high exactly one cycle, the cycle after the second byte is accepted (latency 1). Colours/x/y hold until the next pixel.
- Back-to-back bytes on consecutive cycles give one pixel per 2 cycles. Gaps in `cam_byte_valid_i` are tolerated in any state.
- `frame_done_o`/`frame_err_o` are registered, one cycle after the vsync rising edge is sampled.
- HREF edge and valid byte in the same cycle: the byte is accepted first (edge detection uses the registered previous href).
- `rst` mid-line: next cycle all outputs 0, FSM in `S_WAIT_VSYNC`, no frame pulse.

## Configuration
- `CAM_TEST_PATTERN_EN` defined:
  - Adds input `pattern_sel_i` (1 bit).
  - When high, camera bytes are still parsed for timing, but colours are replaced by 8 vertical colour bars. Bar index is `x_o` scaled by IMG_WIDTH/8; bar colour is {R,G,B} = {idx[2],idx[1],idx[0]} each expanded to 0xFF/0x00.
  - Latency and strobes are unchanged.
- Undefined: port absent; colours always from camera.

## Structure
- Package `cam_pkg`: FSM state enum, RGB565 field bit positions, default `IMG_WIDTH`/`IMG_HEIGHT`.
- Sub-module `rgb565_to_rgb888`: purely combinational 16-bit → 3×8-bit expansion, reusable by the display path.

## Test plan
- Bytes 0xF8, 0x00 on one line → `done_o` one cycle after the second byte; R=0xFF, G=0x00, B=0x00; x=0, y=0.
- Bytes 0x07, 0xE0 then 0x08, 0x41 → pixel 0 G=0xFF, R=B=0x00; pixel 1 R=G=B=0x08, x=1.
- 4×2 frame (IMG_WIDTH=4, IMG_HEIGHT=2), valid gaps inserted, then vsync high → 8 `done_o`, last x=3, y=1; `frame_done_o` one pulse.
- HREF drops after 3 bytes → 1 pixel output, partial discarded; at vsync `frame_err_o` pulses and `frame_done_o` stays 0.
- `rst` asserted mid-line → next cycle all outputs 0. Bytes are ignored until a vsync high→low is seen. The following clean frame yields `frame_done_o`.
- With `CAM_TEST_PATTERN_EN`, `pattern_sel_i`=1, IMG_WIDTH=8 → pixel x=5 gives R=0xFF, G=0x00, B=0xFF.
